// File: rtl/vpu_pkg.sv
// Shared definitions for the vector/systolic processing unit: default widths,
// the writeback FSM state encoding and a reference requantization function.
package vpu_pkg;

   localparam int VPU_DATA_WIDTH     = 8;
   localparam int VPU_MATRIX_SIZE    = 8;
   localparam int VPU_ACC_WIDTH      = 32;
   localparam int VPU_DP_ADDR_WIDTH  = 10;
   localparam int VPU_SHIFT_WIDTH    = 5;
   localparam int VPU_ACC_ADDR_WIDTH = $clog2(VPU_MATRIX_SIZE * VPU_MATRIX_SIZE);

   // Clamp limits of the quantized result, held in the extended accumulator width.
   localparam logic signed [VPU_ACC_WIDTH:0] VPU_Q_MAX =
      (VPU_ACC_WIDTH + 1)'((2 ** (VPU_DATA_WIDTH - 1)) - 1);
   localparam logic signed [VPU_ACC_WIDTH:0] VPU_Q_MIN = ~VPU_Q_MAX;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wb_state_t;

   // Rounding arithmetic right shift followed by saturation or truncation,
   // evaluated one bit wider than the accumulator so the rounding add cannot overflow.
   function automatic logic [VPU_DATA_WIDTH-1:0] quantize_sat(
      input logic signed [VPU_ACC_WIDTH-1:0] x,
      input logic [VPU_SHIFT_WIDTH-1:0]      shift,
      input logic                            sat_en
   );
      logic signed [VPU_ACC_WIDTH:0] x_ext;
      logic signed [VPU_ACC_WIDTH:0] half;
      logic signed [VPU_ACC_WIDTH:0] y;
      logic [VPU_DATA_WIDTH-1:0]     q;
      x_ext = {x[VPU_ACC_WIDTH-1], x};
      y     = x_ext;
      if (shift != '0) begin
         half = (VPU_ACC_WIDTH + 1)'(1) << (shift - VPU_SHIFT_WIDTH'(1));
         y    = (x_ext + half) >>> shift;
      end
      q = y[VPU_DATA_WIDTH-1:0];
      if (sat_en) begin
         if (y > VPU_Q_MAX) begin
            q = VPU_Q_MAX[VPU_DATA_WIDTH-1:0];
         end else if (y < VPU_Q_MIN) begin
            q = VPU_Q_MIN[VPU_DATA_WIDTH-1:0];
         end
      end
      return q;
   endfunction

endpackage

// File: rtl/acc_writeback_engine_quantizer.sv
// Combinational requantizer: signed accumulator -> DATA_WIDTH result using a
// rounding arithmetic right shift and optional saturation.
module acc_quantizer
   import vpu_pkg::*;
#(
   parameter int DATA_WIDTH  = VPU_DATA_WIDTH,
   parameter int ACC_WIDTH   = VPU_ACC_WIDTH,
   parameter int SHIFT_WIDTH = VPU_SHIFT_WIDTH
) (
   input  logic [ACC_WIDTH-1:0]   acc_i,
   input  logic [SHIFT_WIDTH-1:0] shift_i,
   input  logic                   sat_en_i,
   output logic [DATA_WIDTH-1:0]  q_o
);

   // One extra bit keeps x + 2^(shift-1) exact for every accumulator value.
   localparam int EW = ACC_WIDTH + 1;
   localparam logic signed [EW-1:0]        Q_MAX  = EW'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [EW-1:0]        Q_MIN  = ~Q_MAX;
   localparam logic [SHIFT_WIDTH-1:0]      SH_ONE = SHIFT_WIDTH'(1);

   logic signed [EW-1:0] x_ext;
   logic signed [EW-1:0] half;
   logic signed [EW-1:0] y;

   // Round-half-up shift, then clamp or keep the low bits.
   always_comb begin
      x_ext = {acc_i[ACC_WIDTH-1], acc_i};
      half  = '0;
      y     = x_ext;
      if (shift_i != '0) begin
         half = EW'(1) << (shift_i - SH_ONE);
         y    = (x_ext + half) >>> shift_i;
      end
      q_o = y[DATA_WIDTH-1:0];
      if (sat_en_i) begin
         if (y > Q_MAX) begin
            q_o = Q_MAX[DATA_WIDTH-1:0];
         end else if (y < Q_MIN) begin
            q_o = Q_MIN[DATA_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/acc_writeback_engine.sv
// Drain stage for the systolic array: on start, reads every accumulator entry
// in index order, requantizes it and writes it to RAM at base_addr + index.
//
// Pipeline:
//   stage 1 (RUN)   : addr_acc presents index k; acc_out returns it next cycle.
//   stage 2 (rd_v)  : acc_out is quantized and captured into we/waddr/wdata.
// Start is a one-cycle pulse honoured only in IDLE; base_addr, shift and sat_en
// are captured at that moment and ignored for the rest of the run. There is no
// back-pressure: once started, one write is produced per cycle until the last.
module acc_writeback_engine
   import vpu_pkg::*;
#(
   parameter int DATA_WIDTH     = VPU_DATA_WIDTH,
   parameter int MATRIX_SIZE    = VPU_MATRIX_SIZE,
   parameter int ACC_WIDTH      = VPU_ACC_WIDTH,
   parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
   parameter int DP_ADDR_WIDTH  = VPU_DP_ADDR_WIDTH,
   parameter int SHIFT_WIDTH    = VPU_SHIFT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DP_ADDR_WIDTH-1:0]  base_addr,
   input  logic [SHIFT_WIDTH-1:0]    shift,
   input  logic                      sat_en,
   output logic                      busy,
   output logic                      done,
   output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
   input  logic [ACC_WIDTH-1:0]      acc_out,
   output logic                      we,
   output logic [DP_ADDR_WIDTH-1:0]  waddr,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic [1:0]                state_dbg
);

   localparam logic [ACC_ADDR_WIDTH-1:0] LAST_IDX =
      ACC_ADDR_WIDTH'(MATRIX_SIZE * MATRIX_SIZE - 1);

   wb_state_t                 state_q, state_d;
   logic [ACC_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                      rd_v_q, rd_v_d;
   logic [ACC_ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
   logic [DP_ADDR_WIDTH-1:0]  base_q, base_d;
   logic [SHIFT_WIDTH-1:0]    shift_q, shift_d;
   logic                      sat_q, sat_d;
   logic                      we_q, we_d;
   logic [DP_ADDR_WIDTH-1:0]  waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [DATA_WIDTH-1:0]     q_data;

   acc_quantizer #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_quant (
      .acc_i    (acc_out),
      .shift_i  (shift_q),
      .sat_en_i (sat_q),
      .q_o      (q_data)
   );

   // Next-state, index walk, parameter capture and write-stage next values.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      base_d   = base_q;
      shift_d  = shift_q;
      sat_d    = sat_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               addr_d  = '0;
               base_d  = base_addr;
               shift_d = shift;
               sat_d   = sat_en;
            end
         end
         RUN: begin
            if (addr_q == LAST_IDX) begin
               state_d = DRAIN;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         DRAIN: begin
            // The last read is in flight while rd_v_q is high; once it has
            // moved into the write register the run can finish.
            if (!rd_v_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rd_v_d   = (state_q == RUN);
      rd_idx_d = addr_q;
      we_d     = rd_v_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      if (rd_v_q) begin
         waddr_d = base_q + DP_ADDR_WIDTH'(rd_idx_q);
         wdata_d = q_data;
      end
      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_q == DRAIN) && (state_d == DONE);
   end

   // State, pipeline and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rd_v_q   <= 1'b0;
         rd_idx_q <= '0;
         base_q   <= '0;
         shift_q  <= '0;
         sat_q    <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rd_v_q   <= rd_v_d;
         rd_idx_q <= rd_idx_d;
         base_q   <= base_d;
         shift_q  <= shift_d;
         sat_q    <= sat_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign addr_acc  = addr_q;
   assign we        = we_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_acc_writeback_engine.sv
// Bench for acc_writeback_engine: accumulator memory model with one-cycle read
// latency, cycle-indexed capture of writes/done/busy, and an expected queue
// of {cycle, waddr, wdata} words built from an independent quantizer model.
module tb_acc_writeback_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [4:0]  shift;
   logic        sat_en;
   logic        busy;
   logic        done;
   logic [5:0]  addr_acc;
   logic [31:0] acc_out;
   logic        we;
   logic [9:0]  waddr;
   logic [7:0]  wdata;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   acc_writeback_engine dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .shift     (shift),
      .sat_en    (sat_en),
      .busy      (busy),
      .done      (done),
      .addr_acc  (addr_acc),
      .acc_out   (acc_out),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .state_dbg (state_dbg)
   );

   // Accumulator array read port: data follows the address by one cycle.
   logic signed [31:0] acc_mem [64];
   always @(posedge clk) acc_out <= acc_mem[addr_acc];

   int checks_total  = 0;
   int checks_passed = 0;

   // Packed scoreboard words: {cycle[15:0], waddr[9:0], wdata[7:0]}.
   logic [33:0] exp_q[$];
   logic [33:0] obs_q[$];
   int          done_log[$];
   logic        busy_log [256];
   logic [5:0]  addr_log [256];
   bit          overlap;

   int          pulse_a, pulse_b, pulse_c, rst_cyc, scramble_cyc;
   logic [9:0]  rs_base;
   logic [4:0]  rs_shift;
   logic        rs_sat;

   function automatic logic [7:0] model_q(input logic signed [31:0] x, input int s, input bit se);
      longint y;
      longint xl;
      xl = x;
      if (s > 0) y = (xl + (longint'(1) << (s - 1))) >>> s;
      else       y = xl;
      if (se) begin
         if (y > 127)       y = 127;
         else if (y < -128) y = -128;
      end
      return y[7:0];
   endfunction

   task automatic push_run(input int cyc0, input logic [9:0] b, input int s, input bit se, input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({16'(cyc0 + 3 + k), 10'(b + k), model_q(acc_mem[k], s, se)});
      end
   endtask

   task automatic clear_ctl();
      pulse_a = -1; pulse_b = -1; pulse_c = -1; rst_cyc = -1; scramble_cyc = -1;
      rs_base = '0; rs_shift = '0; rs_sat = 1'b0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++) begin
         if (i % 8 == 7) acc_mem[i] = $urandom;
         else            acc_mem[i] = $signed($urandom_range(0, 8191)) - 4096;
      end
   endtask

   task automatic launch(input logic [9:0] b, input logic [4:0] s, input logic se);
      @(negedge clk);
      base_addr = b; shift = s; sat_en = se; start = 1'b1; rst = 1'b0;
   endtask

   // Records DUT activity for cycles 1..ncyc after the launch cycle and
   // applies any scheduled mid-run stimulus for the following edge.
   task automatic capture(input int ncyc);
      obs_q.delete();
      done_log.delete();
      overlap = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         start = 1'b0;
         rst   = 1'b0;
         if (we) obs_q.push_back({16'(c), waddr, wdata});
         if (done) done_log.push_back(c);
         if (we && done) overlap = 1;
         busy_log[c] = busy;
         addr_log[c] = addr_acc;
         if (c == scramble_cyc) begin
            base_addr = 10'h2AA; shift = 5'd0; sat_en = ~sat_en;
         end
         if (c == pulse_a || c == pulse_b || c == pulse_c) begin
            start = 1'b1; base_addr = rs_base; shift = rs_shift; sat_en = rs_sat;
         end
         if (c == rst_cyc) rst = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; base_addr = '0; shift = '0; sat_en = 1'b0;
      for (int i = 0; i < 64; i++) acc_mem[i] = '0;
      repeat (3) @(negedge clk);
      checks_total++; if (we !== 1'b0)        $display("FAIL reset_we: got %b want 0", we);               else checks_passed++;
      checks_total++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy);           else checks_passed++;
      checks_total++; if (done !== 1'b0)      $display("FAIL reset_done: got %b want 0", done);           else checks_passed++;
      checks_total++; if (addr_acc !== 6'd0)  $display("FAIL reset_addr_acc: got %h want 0", addr_acc);  else checks_passed++;
      checks_total++; if (waddr !== 10'd0)    $display("FAIL reset_waddr: got %h want 0", waddr);         else checks_passed++;
      checks_total++; if (wdata !== 8'd0)     $display("FAIL reset_wdata: got %h want 0", wdata);         else checks_passed++;
      checks_total++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg);    else checks_passed++;
      rst = 1'b0;
   endtask

   task automatic test_basic_run();
      logic [33:0] e, o;
      clear_ctl();
      for (int i = 0; i < 64; i++) acc_mem[i] = 16 * i;
      for (int k = 0; k < 64; k++) exp_q.push_back({16'(3 + k), 10'(10'h100 + k), 8'(k)});
      launch(10'h100, 5'd4, 1'b1);
      capture(70);
      checks_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
      else checks_passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks_total++;
         if (o !== e) $display("FAIL basic_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                               o[33:18], o[17:8], o[7:0], e[33:18], e[17:8], e[7:0]);
         else checks_passed++;
      end
      exp_q.delete();
      checks_total++;
      if (done_log.size() != 1 || done_log[0] != 67) $display("FAIL basic_done: got %0d pulses first at %0d want 1 at 67", done_log.size(), (done_log.size() > 0) ? done_log[0] : -1);
      else checks_passed++;
      for (int c = 1; c <= 70; c++) begin
         checks_total++;
         if (busy_log[c] !== ((c >= 1 && c <= 66) ? 1'b1 : 1'b0)) $display("FAIL basic_busy: cycle %0d got %b", c, busy_log[c]);
         else checks_passed++;
      end
      for (int c = 1; c <= 64; c++) begin
         checks_total++;
         if (addr_log[c] !== 6'(c - 1)) $display("FAIL basic_addr_acc: cycle %0d got %0d want %0d", c, addr_log[c], c - 1);
         else checks_passed++;
      end
      checks_total++; if (overlap) $display("FAIL basic_overlap: got done&&we want never"); else checks_passed++;
      checks_total++; if (state_dbg !== 2'd0) $display("FAIL basic_end_state: got %0d want 0", state_dbg); else checks_passed++;
   endtask

   task automatic test_sat_trunc();
      logic [33:0] e, o;
      logic [7:0]  want0, want1;
      for (int pass = 0; pass < 2; pass++) begin
         clear_ctl();
         fill_random();
         acc_mem[0] = -300;
         acc_mem[1] = 300;
         want0 = (pass == 0) ? 8'h80 : 8'hD4;
         want1 = (pass == 0) ? 8'h7F : 8'h2C;
         push_run(0, 10'h010, 0, (pass == 0), 64);
         launch(10'h010, 5'd0, (pass == 0));
         capture(70);
         checks_total++;
         if (obs_q.size() < 2 || obs_q[0][7:0] !== want0 || obs_q[1][7:0] !== want1)
            $display("FAIL sat_trunc_fixed: pass %0d got %h %h want %h %h", pass,
                     (obs_q.size() > 0) ? obs_q[0][7:0] : 8'hxx, (obs_q.size() > 1) ? obs_q[1][7:0] : 8'hxx, want0, want1);
         else checks_passed++;
         checks_total++;
         if (obs_q.size() != exp_q.size()) $display("FAIL sat_trunc_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
         else checks_passed++;
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks_total++;
            if (o !== e) $display("FAIL sat_trunc_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                                  o[33:18], o[17:8], o[7:0], e[33:18], e[17:8], e[7:0]);
            else checks_passed++;
         end
         exp_q.delete();
      end
   endtask

   task automatic test_rounding();
      logic [33:0] e, o;
      clear_ctl();
      fill_random();
      acc_mem[0] = 24; acc_mem[1] = -24; acc_mem[2] = 7; acc_mem[3] = 8;
      push_run(0, 10'h000, 4, 1'b1, 64);
      launch(10'h000, 5'd4, 1'b1);
      capture(70);
      checks_total++;
      if (obs_q.size() < 4 || obs_q[0][7:0] !== 8'h02 || obs_q[1][7:0] !== 8'hFF ||
          obs_q[2][7:0] !== 8'h00 || obs_q[3][7:0] !== 8'h01)
         $display("FAIL rounding_fixed: got %0d writes, first data %h want 02 ff 00 01", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0][7:0] : 8'hxx);
      else checks_passed++;
      checks_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL rounding_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
      else checks_passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks_total++;
         if (o !== e) $display("FAIL rounding_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                               o[33:18], o[17:8], o[7:0], e[33:18], e[17:8], e[7:0]);
         else checks_passed++;
      end
      exp_q.delete();
   endtask

   task automatic test_addr_wrap();
      logic [33:0] e, o;
      int          s;
      bit          se;
      clear_ctl();
      fill_random();
      s  = $urandom_range(0, 12);
      se = 1'($urandom_range(0, 1));
      push_run(0, 10'h3F0, s, se, 64);
      launch(10'h3F0, 5'(s), se);
      capture(70);
      checks_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL wrap_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
      else checks_passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks_total++;
         if (o !== e) $display("FAIL wrap_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                               o[33:18], o[17:8], o[7:0], e[33:18], e[17:8], e[7:0]);
         else checks_passed++;
      end
      exp_q.delete();
      checks_total++;
      if (done_log.size() != 1 || done_log[0] != 67) $display("FAIL wrap_done: got %0d pulses want 1 at 67", done_log.size());
      else checks_passed++;
   endtask

   task automatic test_ignored_start();
      logic [33:0] e, o;
      clear_ctl();
      fill_random();
      pulse_a = 10; pulse_b = 67; pulse_c = 68; scramble_cyc = 5;
      rs_base = 10'h200; rs_shift = 5'd2; rs_sat = 1'b0;
      push_run(0, 10'h0C0, 3, 1'b1, 64);
      push_run(68, 10'h200, 2, 1'b0, 64);
      launch(10'h0C0, 5'd3, 1'b1);
      capture(140);
      checks_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL ignored_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
      else checks_passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks_total++;
         if (o !== e) $display("FAIL ignored_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                               o[33:18], o[17:8], o[7:0], e[33:18], e[17:8], e[7:0]);
         else checks_passed++;
      end
      exp_q.delete();
      checks_total++;
      if (done_log.size() != 2 || done_log[0] != 67 || done_log[1] != 135)
         $display("FAIL ignored_done: got %0d pulses want 2 at 67 and 135", done_log.size());
      else checks_passed++;
      for (int c = 1; c <= 140; c++) begin
         checks_total++;
         if (busy_log[c] !== (((c >= 1 && c <= 66) || (c >= 69 && c <= 134)) ? 1'b1 : 1'b0))
            $display("FAIL ignored_busy: cycle %0d got %b", c, busy_log[c]);
         else checks_passed++;
      end
      checks_total++; if (overlap) $display("FAIL ignored_overlap: got done&&we want never"); else checks_passed++;
   endtask

   task automatic test_reset_midrun();
      logic [33:0] e, o;
      clear_ctl();
      fill_random();
      rst_cyc = 20; pulse_a = 25;
      rs_base = 10'h080; rs_shift = 5'd1; rs_sat = 1'b0;
      push_run(0, 10'h040, 1, 1'b1, 18);
      push_run(25, 10'h080, 1, 1'b0, 64);
      launch(10'h040, 5'd1, 1'b1);
      capture(95);
      checks_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL midrst_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
      else checks_passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks_total++;
         if (o !== e) $display("FAIL midrst_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                               o[33:18], o[17:8], o[7:0], e[33:18], e[17:8], e[7:0]);
         else checks_passed++;
      end
      exp_q.delete();
      checks_total++;
      if (done_log.size() != 1 || done_log[0] != 92) $display("FAIL midrst_done: got %0d pulses want 1 at 92", done_log.size());
      else checks_passed++;
      for (int c = 1; c <= 95; c++) begin
         checks_total++;
         if (busy_log[c] !== (((c >= 1 && c <= 20) || (c >= 26 && c <= 91)) ? 1'b1 : 1'b0))
            $display("FAIL midrst_busy: cycle %0d got %b", c, busy_log[c]);
         else checks_passed++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; shift = '0; sat_en = 1'b0;
      clear_ctl();
      test_reset();
      test_basic_run();
      test_sat_trunc();
      test_rounding();
      test_addr_wrap();
      test_ignored_start();
      test_reset_midrun();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
